// File: rtl/uart_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_capture
// Purpose  : Parametrised UART receiver. It handles 5..9 data bits, optional
//            even or odd parity and 1 or 2 stop bits. Each received frame is
//            stored with its parity and stop-bit error flags in a show-ahead
//            FIFO, which is read through a valid/ready stream.
// Ports    : clk_i, reset_i (sync, active-high) | rx_i serial line (idle 1)
//            data_o/parity_err_o/frame_err_o : head-of-FIFO entry
//            valid_o/ready_i : stream handshake, fifo_count_o : occupancy
//            overrun_o (sticky, cleared by clr_overrun_i), break_o
// Options  : define UART_RX_BREAK_DETECT_EN to detect line breaks. A break is
//            an all-zero frame; it is not stored and break_o pulses instead.
//            When undefined, break_o is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_capture #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             rx_i,
    output logic [DATA_BITS-1:0]             data_o,
    output logic                             parity_err_o,
    output logic                             frame_err_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o,
    output logic                             overrun_o,
    input  logic                             clr_overrun_i,
    output logic                             break_o
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);
    localparam int c_PTR_W        = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W        = $clog2(FIFO_DEPTH + 1);
    localparam int c_ENT_W        = DATA_BITS + 2;

    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = 1;
    localparam logic [3:0]         c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0]         c_BIT_ONE   = 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = 1;
    localparam logic [c_OCC_W-1:0] c_OCC_ONE   = 1;
    localparam logic [c_OCC_W-1:0] c_OCC_FULL  = c_OCC_W'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Line synchronizer; r_rx_prev provides the falling-edge reference
    // ------------------------------------------------------------------
    logic r_rx_meta, r_rx_s, r_rx_prev;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    logic [2:0]           r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_clk_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_stop_err;
    logic                 w_tick;
    logic                 w_commit;

    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_rx_prev && !r_rx_s) w_state_nxt = c_ST_START;
            end
            c_ST_START: begin
                // Sample the start bit at mid-bit to reject glitches.
                w_tick = (r_clk_cnt == c_HALF_LAST);
                if (w_tick) w_state_nxt = r_rx_s ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                w_tick = (r_clk_cnt == c_BIT_LAST);
                if (w_tick && r_bit_cnt == c_DATA_LAST)
                    w_state_nxt = (PARITY != 0) ? c_ST_PARITY : c_ST_STOP;
            end
            c_ST_PARITY: begin
                w_tick = (r_clk_cnt == c_BIT_LAST);
                if (w_tick) w_state_nxt = c_ST_STOP;
            end
            c_ST_STOP: begin
                w_tick = (r_clk_cnt == c_BIT_LAST);
                if (w_tick && r_bit_cnt == c_STOP_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= c_ST_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_IDLE || w_tick || w_state_nxt != r_state)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + c_CNT_ONE;
            if (w_state_nxt != r_state)
                r_bit_cnt <= '0;
            else if (w_tick)
                r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
            // Per-frame flags start clean whenever the receiver is idle.
            if (r_state == c_ST_IDLE) begin
                r_par_bit  <= 1'b0;
                r_stop_err <= 1'b0;
            end
            if (w_tick && r_state == c_ST_DATA)
                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (w_tick && r_state == c_ST_PARITY)
                r_par_bit <= r_rx_s;
            if (w_tick && r_state == c_ST_STOP && !r_rx_s)
                r_stop_err <= 1'b1;
        end
    end

    // The entry includes the last stop sample, which is taken in the commit cycle.
    logic               w_perr, w_ferr, w_is_break;
    logic [c_ENT_W-1:0] w_entry;

    assign w_perr  = (PARITY != 0) && ((^{r_shift, r_par_bit}) != (PARITY == 2));
    assign w_ferr  = r_stop_err | ~r_rx_s;
    assign w_entry = {w_perr, w_ferr, r_shift};

`ifdef UART_RX_BREAK_DETECT_EN
    logic r_stop_zero;
    logic r_break;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stop_zero <= 1'b1;
            r_break     <= 1'b0;
        end else begin
            r_break <= w_is_break;
            if (r_state == c_ST_IDLE)
                r_stop_zero <= 1'b1;
            else if (w_tick && r_state == c_ST_STOP && r_rx_s)
                r_stop_zero <= 1'b0;
        end
    end

    assign w_is_break = w_commit && (r_shift == '0) && !r_par_bit && r_stop_zero && !r_rx_s;
    assign break_o    = r_break;
`else
    assign w_is_break = 1'b0;
    assign break_o    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_OCC_W-1:0] r_count;
    logic               r_overrun;
    logic               w_pop, w_full, w_push_req, w_push, w_drop;
    logic [c_ENT_W-1:0] w_head;

    assign w_full     = (r_count == c_OCC_FULL);
    assign w_pop      = valid_o && ready_i;
    assign w_push_req = w_commit && !w_is_break;
    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_OCC_ONE;
                2'b01:   r_count <= r_count - c_OCC_ONE;
                default: r_count <= r_count;
            endcase
            // If a drop and a clear happen in the same cycle, the drop wins.
            if (w_drop)
                r_overrun <= 1'b1;
            else if (clr_overrun_i)
                r_overrun <= 1'b0;
        end
    end

    // The head is forced to 0 while empty so that the outputs are 0 after reset.
    assign w_head       = r_mem[r_rd_ptr];
    assign valid_o      = (r_count != '0);
    assign data_o       = valid_o ? w_head[DATA_BITS-1:0] : '0;
    assign frame_err_o  = valid_o & w_head[DATA_BITS];
    assign parity_err_o = valid_o & w_head[DATA_BITS+1];
    assign fifo_count_o = r_count;
    assign overrun_o    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_capture
// Purpose  : Self-checking bench for uart_rx_capture at 10 clocks per bit.
//            Instance A is 8N1 with a 16-entry FIFO. Instance B is 8E1.
//            A frame-level model predicts the FIFO contents and the overrun
//            state. A compare process checks every popped entry against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_capture;

`ifdef UART_RX_BREAK_DETECT_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif
    localparam int BIT_CLKS = 10;
    localparam int DEPTH    = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       r_rx_a, r_ready_a, r_clr_a;
    logic       r_rx_b, r_ready_b, r_clr_b;
    logic [7:0] w_data_a, w_data_b;
    logic       w_perr_a, w_ferr_a, w_valid_a, w_ovr_a, w_brk_a;
    logic       w_perr_b, w_ferr_b, w_valid_b, w_ovr_b, w_brk_b;
    logic [4:0] w_cnt_a, w_cnt_b;

    always #5 clk = ~clk;

    uart_rx_capture #(
        .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) u_dut_a (
        .clk_i(clk), .reset_i(reset), .rx_i(r_rx_a),
        .data_o(w_data_a), .parity_err_o(w_perr_a), .frame_err_o(w_ferr_a),
        .valid_o(w_valid_a), .ready_i(r_ready_a), .fifo_count_o(w_cnt_a),
        .overrun_o(w_ovr_a), .clr_overrun_i(r_clr_a), .break_o(w_brk_a)
    );

    uart_rx_capture #(
        .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) u_dut_b (
        .clk_i(clk), .reset_i(reset), .rx_i(r_rx_b),
        .data_o(w_data_b), .parity_err_o(w_perr_b), .frame_err_o(w_ferr_b),
        .valid_o(w_valid_b), .ready_i(r_ready_b), .fifo_count_o(w_cnt_b),
        .overrun_o(w_ovr_b), .clr_overrun_i(r_clr_b), .break_o(w_brk_b)
    );

    int checks = 0;
    int failures = 0;

    // Frame-level model: one queue of expected {perr, ferr, data} per instance.
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    bit         ovr_model_a = 1'b0;
    int         brk_model_a = 0;

    // Observations made by the compare process.
    int         cyc = 0;
    int         pops_a = 0, pops_b = 0;
    int         vcyc_a = 0, brk_cnt_a = 0, brk_cnt_b = 0;
    int         rise_cyc_a = 0;
    logic       prev_valid_a = 1'b0;
    logic [9:0] last_a = '0, last_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [9:0] got;
        logic [9:0] want;
        if (!reset) begin
            if (w_valid_a) vcyc_a++;
            if (w_valid_a && !prev_valid_a) rise_cyc_a = cyc;
            prev_valid_a = w_valid_a;
            if (w_brk_a) brk_cnt_a++;
            if (w_brk_b) brk_cnt_b++;
            if (w_valid_a && r_ready_a) begin
                got = {w_perr_a, w_ferr_a, w_data_a};
                checks++;
                if (exp_a.size() == 0) begin
                    failures++;
                    $display("FAIL pop_a: got entry %h, model expected no entry", got);
                end else begin
                    want = exp_a.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL pop_a: got {perr,ferr,data}=%h expected %h", got, want);
                    end
                end
                last_a = got;
                pops_a++;
            end
            if (w_valid_b && r_ready_b) begin
                got = {w_perr_b, w_ferr_b, w_data_b};
                checks++;
                if (exp_b.size() == 0) begin
                    failures++;
                    $display("FAIL pop_b: got entry %h, model expected no entry", got);
                end else begin
                    want = exp_b.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL pop_b: got {perr,ferr,data}=%h expected %h", got, want);
                    end
                end
                last_b = got;
                pops_b++;
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int sel, input logic v);
        if (sel == 0) r_rx_a = v;
        else          r_rx_b = v;
        tick(BIT_CLKS);
    endtask

    // pbit < 0 means that no parity bit is sent. Instance B checks even parity.
    task automatic send(input int sel, input logic [7:0] d, input int pbit, input logic stop);
        logic perr, ferr, brk;
        perr = (pbit >= 0) && ((($countones(d) + pbit) % 2) != 0);
        ferr = !stop;
        brk  = (d == 8'h00) && (pbit <= 0) && !stop;
        if (sel == 0) begin
            if (BRK_EN && brk)
                brk_model_a++;
            else if (exp_a.size() >= DEPTH && !r_ready_a)
                ovr_model_a = 1'b1;
            else
                exp_a.push_back({perr, ferr, d});
        end else begin
            exp_b.push_back({perr, ferr, d});
        end
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (pbit >= 0) drive_bit(sel, pbit[0]);
        drive_bit(sel, stop);
    endtask

    task automatic quiet_a(input string tag);
        check({tag, "_count_a"}, int'(w_cnt_a), exp_a.size());
        check({tag, "_valid_a"}, int'(w_valid_a), int'(exp_a.size() != 0));
        check({tag, "_ovr_a"},   int'(w_ovr_a), int'(ovr_model_a));
    endtask

    initial begin
        int t0;
        int snap;
        reset = 1'b1;
        r_rx_a = 1'b1; r_ready_a = 1'b1; r_clr_a = 1'b0;
        r_rx_b = 1'b1; r_ready_b = 1'b1; r_clr_b = 1'b0;
        tick(5);
        reset = 1'b0;
        tick(3);

        // Reset state
        quiet_a("reset");
        check("reset_brk_a", int'(w_brk_a), 0);
        check("reset_count_b", int'(w_cnt_b), 0);
        check("reset_valid_b", int'(w_valid_b), 0);

        // 1: 8N1 0xA5, consumed immediately
        t0 = cyc;
        send(0, 8'hA5, -1, 1'b1);
        tick(10);
        checks++;
        if (rise_cyc_a - t0 < 90 || rise_cyc_a - t0 > 102) begin
            failures++;
            $display("FAIL commit_latency: got=%0d cycles expected 90..102", rise_cyc_a - t0);
        end
        check("t1_valid_cycles", vcyc_a, 1);
        check("t1_last_entry", int'(last_a), 10'h0A5);
        quiet_a("t1");

        // 2: 3-cycle glitch is a false start
        snap = pops_a;
        r_rx_a = 1'b0;
        tick(3);
        r_rx_a = 1'b1;
        tick(40);
        check("t2_no_pop", pops_a, snap);
        quiet_a("t2");

        // 3: even parity on instance B
        send(1, 8'h03, 1, 1'b1);
        tick(10);
        check("t3_perr_set", int'(last_b), {1'b1, 1'b0, 8'h03});
        send(1, 8'h03, 0, 1'b1);
        tick(10);
        check("t3_perr_clr", int'(last_b), {1'b0, 1'b0, 8'h03});
        check("t3_pops_b", pops_b, 2);

        // 4: stop bit 0, then the line is held low
        send(0, 8'h5A, -1, 1'b0);
        tick(5);
        check("t4_ferr_entry", int'(last_a), {1'b0, 1'b1, 8'h5A});
        snap = pops_a;
        tick(30);
        r_rx_a = 1'b1;
        tick(30);
        check("t4_no_more_pops", pops_a, snap);
        quiet_a("t4");

        // 5: 17 frames into a 16-deep FIFO with the consumer stalled
        r_ready_a = 1'b0;
        for (int i = 0; i <= 16; i++) send(0, 8'(i), -1, 1'b1);
        tick(20);
        check("t5_full_count", int'(w_cnt_a), 16);
        check("t5_overrun", int'(w_ovr_a), 1);
        quiet_a("t5_full");
        snap = pops_a;
        r_ready_a = 1'b1;
        tick(30);
        check("t5_drained", pops_a - snap, 16);
        check("t5_last", int'(last_a), 10'h00F);
        quiet_a("t5_drain");
        r_clr_a = 1'b1;
        ovr_model_a = 1'b0;
        tick(1);
        r_clr_a = 1'b0;
        tick(2);
        check("t5_ovr_cleared", int'(w_ovr_a), 0);

        // Reset mid-frame discards the FIFO and the partial frame
        r_ready_a = 1'b0;
        send(0, 8'h11, -1, 1'b1);
        tick(10);
        check("rst_pre_count", int'(w_cnt_a), 1);
        r_rx_a = 1'b0;
        tick(40);
        r_rx_a = 1'b1;
        reset = 1'b1;
        exp_a.delete();
        tick(3);
        reset = 1'b0;
        tick(30);
        quiet_a("rst_mid");
        r_ready_a = 1'b1;
        send(0, 8'h3C, -1, 1'b1);
        tick(10);
        check("rst_post_frame", int'(last_a), 10'h03C);

        // 6: all-zero frame (a break when detection is enabled)
        snap = pops_a;
        send(0, 8'h00, -1, 1'b0);
        tick(5);
        r_rx_a = 1'b1;
        tick(20);
        check("t6_break_pulses", brk_cnt_a, brk_model_a);
        check("t6_pops", pops_a - snap, BRK_EN ? 0 : 1);
        if (!BRK_EN) check("t6_entry", int'(last_a), {1'b0, 1'b1, 8'h00});
        quiet_a("t6");
        check("b_break_never", brk_cnt_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
